// File: rtl/issue_select_pkg.sv
// rtl/issue_select_pkg.sv - shared types, widths and default caps for the issue-select stage
package issue_select_pkg;

  localparam int DEF_RS_SZ    = 16;
  localparam int DEF_N        = 2;
  localparam int DEF_NUM_MULT = 1;
  localparam int DEF_NUM_BR   = 1;
  localparam int DEF_NUM_MEM  = 1;

  localparam int B_MASK_WIDTH = 4;
  typedef logic [B_MASK_WIDTH-1:0] B_MASK_MASK;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_BRANCH = 3'd2,
    FU_LOAD   = 3'd3,
    FU_STORE  = 3'd4
  } FU_TYPE;

  typedef struct packed {
    logic [31:0] inst;
    logic [5:0]  dest_tag;
    FU_TYPE      fu_type;
    B_MASK_MASK  b_mask;
    logic        Source1_ready;
    logic        Source2_ready;
  } RS_PACKET;

  typedef struct packed {
    logic [31:0] inst;
    logic [5:0]  dest_tag;
    FU_TYPE      fu_type;
    B_MASK_MASK  b_mask;
  } ISSUE_PACKET;

  // Copy an RS entry into issue form, dropping any b-mask bits resolved this cycle.
  function automatic ISSUE_PACKET to_issue(RS_PACKET p, B_MASK_MASK clr);
    ISSUE_PACKET q;
    q.inst     = p.inst;
    q.dest_tag = p.dest_tag;
    q.fu_type  = p.fu_type;
    q.b_mask   = p.b_mask & ~clr;
    return q;
  endfunction

endpackage

// File: rtl/issue_select_if.sv
// rtl/issue_select_if.sv - RS-to-issue and issue-to-execute signal bundle
// slave modport (issue_select): RS_data, RS_valid, ex_stall, b_mm_resolve, b_mm_mispred in;
//   rs_data_issuing, issue_packets, issue_valid out. master modport is the mirror.
interface issue_select_if
  import issue_select_pkg::*;
#(
  parameter int RS_SZ = DEF_RS_SZ,
  parameter int N     = DEF_N
);
  RS_PACKET          RS_data [RS_SZ];
  logic [RS_SZ-1:0]  RS_valid;
  logic              ex_stall;
  B_MASK_MASK        b_mm_resolve;
  logic              b_mm_mispred;
  logic [RS_SZ-1:0]  rs_data_issuing;
  ISSUE_PACKET       issue_packets [N];
  logic [N-1:0]      issue_valid;

  modport slave (
    input  RS_data, RS_valid, ex_stall, b_mm_resolve, b_mm_mispred,
    output rs_data_issuing, issue_packets, issue_valid
  );

  modport master (
    output RS_data, RS_valid, ex_stall, b_mm_resolve, b_mm_mispred,
    input  rs_data_issuing, issue_packets, issue_valid
  );
endinterface

// File: rtl/issue_select_rr_pick_seq.sv
// rtl/issue_select_rr_pick_seq.sv - rotating priority scan with per-FU-class caps
// in : req (ready requesters), fu (class per entry), rr_ptr (scan start)
// out: grant vector, slot_idx/slot_vld (grants in scan order), last_idx, any_grant
module rr_pick_seq
  import issue_select_pkg::*;
#(
  parameter int RS_SZ    = DEF_RS_SZ,
  parameter int N        = DEF_N,
  parameter int NUM_MULT = DEF_NUM_MULT,
  parameter int NUM_BR   = DEF_NUM_BR,
  parameter int NUM_MEM  = DEF_NUM_MEM,
  localparam int IDX_W   = $clog2(RS_SZ)
) (
  input  logic [RS_SZ-1:0] req,
  input  FU_TYPE           fu [RS_SZ],
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [RS_SZ-1:0] grant,
  output logic [IDX_W-1:0] slot_idx [N],
  output logic [N-1:0]     slot_vld,
  output logic [IDX_W-1:0] last_idx,
  output logic             any_grant
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             cap_ok;
    int               n_total;
    int               n_mult;
    int               n_br;
    int               n_mem;

    grant     = '0;
    slot_vld  = '0;
    for (int s = 0; s < N; s++) slot_idx[s] = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    n_total   = 0;
    n_mult    = 0;
    n_br      = 0;
    n_mem     = 0;

    for (int k = 0; k < RS_SZ; k++) begin
      // RS_SZ is a power of two, so the IDX_W-bit add wraps the scan naturally.
      idx = rr_ptr + IDX_W'(k);
      case (fu[idx])
        FU_MULT:           cap_ok = (n_mult < NUM_MULT);
        FU_BRANCH:         cap_ok = (n_br < NUM_BR);
        FU_LOAD, FU_STORE: cap_ok = (n_mem < NUM_MEM);
        default:           cap_ok = 1'b1;
      endcase
      // A capped requester is skipped; the scan keeps going past it.
      if (req[idx] && cap_ok && (n_total < N)) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < N; s++) begin
          if (s == n_total) begin
            slot_idx[s] = idx;
            slot_vld[s] = 1'b1;
          end
        end
        case (fu[idx])
          FU_MULT:           n_mult = n_mult + 1;
          FU_BRANCH:         n_br   = n_br + 1;
          FU_LOAD, FU_STORE: n_mem  = n_mem + 1;
          default:           ;
        endcase
        n_total   = n_total + 1;
        last_idx  = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// rtl/issue_select.sv - issue-select stage: RS grant, round-robin pointer, issue register
// clock/reset: rising-edge clock, async active-low reset
// bus (slave): RS contents and branch resolve in; same-cycle grant to RS and registered bundle to execute out
module issue_select
  import issue_select_pkg::*;
#(
  parameter int RS_SZ    = DEF_RS_SZ,
  parameter int N        = DEF_N,
  parameter int NUM_MULT = DEF_NUM_MULT,
  parameter int NUM_BR   = DEF_NUM_BR,
  parameter int NUM_MEM  = DEF_NUM_MEM
) (
  input  logic            clock,
  input  logic            reset,
  issue_select_if.slave   bus
);

  localparam int IDX_W = $clog2(RS_SZ);

  logic [IDX_W-1:0] rr_ptr;
  logic [RS_SZ-1:0] req;
  FU_TYPE           fu [RS_SZ];
  logic [RS_SZ-1:0] grant;
  logic [IDX_W-1:0] slot_idx [N];
  logic [N-1:0]     slot_vld;
  logic [IDX_W-1:0] last_idx;
  logic             any_grant;

  // Only stored ready bits count; entries on a mispredicted path are not requested.
  always_comb begin
    req = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      fu[i]  = bus.RS_data[i].fu_type;
      req[i] = bus.RS_valid[i] & bus.RS_data[i].Source1_ready & bus.RS_data[i].Source2_ready
             & ~(bus.b_mm_mispred & (|(bus.RS_data[i].b_mask & bus.b_mm_resolve)));
    end
  end

  rr_pick_seq #(
    .RS_SZ   (RS_SZ),
    .N       (N),
    .NUM_MULT(NUM_MULT),
    .NUM_BR  (NUM_BR),
    .NUM_MEM (NUM_MEM)
  ) u_pick (
    .req      (req),
    .fu       (fu),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .slot_idx (slot_idx),
    .slot_vld (slot_vld),
    .last_idx (last_idx),
    .any_grant(any_grant)
  );

  // The RS frees granted entries at the next edge, so nothing may be reported
  // while the register cannot capture or while reset is held.
  assign bus.rs_data_issuing = (reset && !bus.ex_stall) ? grant : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr            <= '0;
      bus.issue_valid   <= '0;
      bus.issue_packets <= '{default: '0};
    end else if (bus.ex_stall) begin
      // Held bundle still tracks branch resolution.
      for (int s = 0; s < N; s++) begin
        bus.issue_packets[s].b_mask <= bus.issue_packets[s].b_mask & ~bus.b_mm_resolve;
        if (bus.b_mm_mispred && (|(bus.issue_packets[s].b_mask & bus.b_mm_resolve)))
          bus.issue_valid[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        bus.issue_valid[s] <= slot_vld[s];
        if (slot_vld[s])
          bus.issue_packets[s] <= to_issue(bus.RS_data[slot_idx[s]], bus.b_mm_resolve);
        else
          bus.issue_packets[s] <= '0;
      end
      if (any_grant)
        rr_ptr <= last_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - directed self-checking bench for issue_select
module tb_issue_select;
  import issue_select_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  issue_select_if #(.RS_SZ(16), .N(2)) bus ();

  issue_select dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rs();
    bus.RS_valid = '0;
    for (int i = 0; i < 16; i++) bus.RS_data[i] = '0;
  endtask

  task automatic set_entry(input int i, input FU_TYPE f, input logic [3:0] bm);
    RS_PACKET p;
    p.inst          = 32'h1000 + i;
    p.dest_tag      = 6'(i);
    p.fu_type       = f;
    p.b_mask        = bm;
    p.Source1_ready = 1'b1;
    p.Source2_ready = 1'b1;
    bus.RS_data[i]  = p;
    bus.RS_valid[i] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ex_stall = 1'b0;
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    clear_rs();
    #2;
    reset = 1'b0;
    set_entry(0, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0000) begin
      fails++; $display("FAIL reset_grant: got %h expected %h", bus.rs_data_issuing, 16'h0000);
    end
    tick();
    checks++;
    if (bus.issue_valid !== 2'b00) begin
      fails++; $display("FAIL reset_valid: got %b expected %b", bus.issue_valid, 2'b00);
    end
    checks++;
    if (dut.rr_ptr !== 4'd0) begin
      fails++; $display("FAIL reset_rr_ptr: got %0d expected %0d", dut.rr_ptr, 0);
    end
    clear_rs();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_alu_pair();
    set_entry(3, FU_ALU, 4'b0000);
    set_entry(9, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0208) begin
      fails++; $display("FAIL alu_grant: got %h expected %h", bus.rs_data_issuing, 16'h0208);
    end
    tick();
    clear_rs();
    checks++;
    if (bus.issue_valid !== 2'b11) begin
      fails++; $display("FAIL alu_valid: got %b expected %b", bus.issue_valid, 2'b11);
    end
    checks++;
    if (bus.issue_packets[0].dest_tag !== 6'd3 || bus.issue_packets[1].dest_tag !== 6'd9) begin
      fails++; $display("FAIL alu_slots: got %0d,%0d expected 3,9",
                        bus.issue_packets[0].dest_tag, bus.issue_packets[1].dest_tag);
    end
    checks++;
    if (bus.issue_packets[1].inst !== 32'h1009) begin
      fails++; $display("FAIL alu_inst: got %h expected %h", bus.issue_packets[1].inst, 32'h1009);
    end
    checks++;
    if (dut.rr_ptr !== 4'd10) begin
      fails++; $display("FAIL alu_rr_ptr: got %0d expected %0d", dut.rr_ptr, 10);
    end
  endtask

  task automatic test_empty();
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0000) begin
      fails++; $display("FAIL empty_grant: got %h expected %h", bus.rs_data_issuing, 16'h0000);
    end
    tick();
    checks++;
    if (bus.issue_valid !== 2'b00 || dut.rr_ptr !== 4'd10) begin
      fails++; $display("FAIL empty_hold: got valid %b rr %0d expected valid 00 rr 10",
                        bus.issue_valid, dut.rr_ptr);
    end
  endtask

  task automatic test_mult_cap();
    set_entry(1, FU_MULT, 4'b0000);
    set_entry(2, FU_MULT, 4'b0000);
    set_entry(5, FU_MULT, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0002) begin
      fails++; $display("FAIL mult_grant1: got %h expected %h", bus.rs_data_issuing, 16'h0002);
    end
    tick();
    bus.RS_valid[1] = 1'b0;
    checks++;
    if (bus.issue_valid !== 2'b01 || bus.issue_packets[0].dest_tag !== 6'd1 || dut.rr_ptr !== 4'd2) begin
      fails++; $display("FAIL mult_reg1: got valid %b tag %0d rr %0d expected valid 01 tag 1 rr 2",
                        bus.issue_valid, bus.issue_packets[0].dest_tag, dut.rr_ptr);
    end
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0004) begin
      fails++; $display("FAIL mult_grant2: got %h expected %h", bus.rs_data_issuing, 16'h0004);
    end
    tick();
    clear_rs();
    checks++;
    if (bus.issue_valid !== 2'b01 || bus.issue_packets[0].dest_tag !== 6'd2 || dut.rr_ptr !== 4'd3) begin
      fails++; $display("FAIL mult_reg2: got valid %b tag %0d rr %0d expected valid 01 tag 2 rr 3",
                        bus.issue_valid, bus.issue_packets[0].dest_tag, dut.rr_ptr);
    end
  endtask

  task automatic test_mem_branch_cap();
    set_entry(4, FU_LOAD, 4'b0000);
    set_entry(6, FU_STORE, 4'b0000);
    set_entry(8, FU_BRANCH, 4'b0000);
    set_entry(9, FU_BRANCH, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0110) begin
      fails++; $display("FAIL cap_grant: got %h expected %h", bus.rs_data_issuing, 16'h0110);
    end
    tick();
    clear_rs();
    checks++;
    if (bus.issue_packets[0].dest_tag !== 6'd4 || bus.issue_packets[1].dest_tag !== 6'd8 || dut.rr_ptr !== 4'd9) begin
      fails++; $display("FAIL cap_reg: got tags %0d,%0d rr %0d expected 4,8 rr 9",
                        bus.issue_packets[0].dest_tag, bus.issue_packets[1].dest_tag, dut.rr_ptr);
    end
  endtask

  task automatic test_wrap();
    set_entry(14, FU_ALU, 4'b0000);
    tick();
    clear_rs();
    checks++;
    if (dut.rr_ptr !== 4'd15) begin
      fails++; $display("FAIL wrap_setup: got %0d expected %0d", dut.rr_ptr, 15);
    end
    set_entry(15, FU_ALU, 4'b0000);
    set_entry(0, FU_ALU, 4'b0000);
    set_entry(5, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h8001) begin
      fails++; $display("FAIL wrap_grant: got %h expected %h", bus.rs_data_issuing, 16'h8001);
    end
    tick();
    clear_rs();
    checks++;
    if (bus.issue_packets[0].dest_tag !== 6'd15 || bus.issue_packets[1].dest_tag !== 6'd0 || dut.rr_ptr !== 4'd1) begin
      fails++; $display("FAIL wrap_reg: got tags %0d,%0d rr %0d expected 15,0 rr 1",
                        bus.issue_packets[0].dest_tag, bus.issue_packets[1].dest_tag, dut.rr_ptr);
    end
  endtask

  task automatic test_all_ready();
    for (int i = 0; i < 16; i++) set_entry(i, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0006) begin
      fails++; $display("FAIL all_grant: got %h expected %h", bus.rs_data_issuing, 16'h0006);
    end
    tick();
    clear_rs();
    checks++;
    if (dut.rr_ptr !== 4'd3) begin
      fails++; $display("FAIL all_rr_ptr: got %0d expected %0d", dut.rr_ptr, 3);
    end
  endtask

  task automatic test_stall_mispred();
    set_entry(3, FU_ALU, 4'b0010);
    set_entry(4, FU_ALU, 4'b0001);
    tick();
    clear_rs();
    checks++;
    if (bus.issue_valid !== 2'b11 || dut.rr_ptr !== 4'd5) begin
      fails++; $display("FAIL smp_setup: got valid %b rr %0d expected 11 rr 5", bus.issue_valid, dut.rr_ptr);
    end
    bus.ex_stall = 1'b1;
    bus.b_mm_resolve = 4'b0010;
    bus.b_mm_mispred = 1'b1;
    set_entry(6, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0000) begin
      fails++; $display("FAIL smp_grant: got %h expected %h", bus.rs_data_issuing, 16'h0000);
    end
    tick();
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    checks++;
    if (bus.issue_valid !== 2'b10 || bus.issue_packets[1].dest_tag !== 6'd4 || dut.rr_ptr !== 4'd5) begin
      fails++; $display("FAIL smp_reg: got valid %b tag1 %0d rr %0d expected 10 tag1 4 rr 5",
                        bus.issue_valid, bus.issue_packets[1].dest_tag, dut.rr_ptr);
    end
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0000) begin
      fails++; $display("FAIL smp_grant2: got %h expected %h", bus.rs_data_issuing, 16'h0000);
    end
  endtask

  task automatic test_stall_correct();
    bus.b_mm_resolve = 4'b0001;
    tick();
    bus.b_mm_resolve = '0;
    checks++;
    if (bus.issue_packets[1].b_mask !== 4'b0000 || bus.issue_valid !== 2'b10) begin
      fails++; $display("FAIL scr_reg: got bmask %b valid %b expected 0000 valid 10",
                        bus.issue_packets[1].b_mask, bus.issue_valid);
    end
    bus.ex_stall = 1'b0;
    clear_rs();
  endtask

  task automatic test_resolve_capture();
    set_entry(7, FU_ALU, 4'b0110);
    bus.b_mm_resolve = 4'b0100;
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0080) begin
      fails++; $display("FAIL cap_res_grant: got %h expected %h", bus.rs_data_issuing, 16'h0080);
    end
    tick();
    clear_rs();
    checks++;
    if (bus.issue_packets[0].b_mask !== 4'b0010 || bus.issue_packets[0].dest_tag !== 6'd7 || bus.issue_valid !== 2'b01) begin
      fails++; $display("FAIL cap_res_reg: got bmask %b tag %0d valid %b expected 0010 tag 7 valid 01",
                        bus.issue_packets[0].b_mask, bus.issue_packets[0].dest_tag, bus.issue_valid);
    end
    bus.b_mm_mispred = 1'b1;
    set_entry(8, FU_ALU, 4'b0100);
    set_entry(9, FU_ALU, 4'b0000);
    #1;
    checks++;
    if (bus.rs_data_issuing !== 16'h0200) begin
      fails++; $display("FAIL mp_exclude: got %h expected %h", bus.rs_data_issuing, 16'h0200);
    end
    tick();
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    clear_rs();
    checks++;
    if (bus.issue_valid !== 2'b01 || bus.issue_packets[0].dest_tag !== 6'd9 || dut.rr_ptr !== 4'd10) begin
      fails++; $display("FAIL mp_reg: got valid %b tag %0d rr %0d expected 01 tag 9 rr 10",
                        bus.issue_valid, bus.issue_packets[0].dest_tag, dut.rr_ptr);
    end
  endtask

  task automatic test_async_reset();
    set_entry(2, FU_ALU, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.issue_valid !== 2'b00 || dut.rr_ptr !== 4'd0) begin
      fails++; $display("FAIL async_reset: got valid %b rr %0d expected 00 rr 0", bus.issue_valid, dut.rr_ptr);
    end
    checks++;
    if (bus.issue_packets[0].dest_tag !== 6'd0 || bus.rs_data_issuing !== 16'h0000) begin
      fails++; $display("FAIL async_reset_data: got tag %0d grant %h expected 0 and 0000",
                        bus.issue_packets[0].dest_tag, bus.rs_data_issuing);
    end
    clear_rs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_alu_pair();
    test_empty();
    test_mult_cap();
    test_mem_branch_cap();
    test_wrap();
    test_all_ready();
    test_stall_mispred();
    test_stall_correct();
    test_resolve_capture();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
